mem_stage: RTL

- Memory-access stage of the 5-stage MIPS pipeline, directly upstream of the write-back stage.
- Owns the word-addressed data memory and performs SW/SH/SB stores with byte-lane merging.
- Reads the aligned word for loads; sign/zero extension stays in write-back.
- Contains the MEM/WB pipeline register that drives PC4/Instr4/Result4/RD4 into write-back, with hold and flush control.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/dm_store_merge.sv | 34 +++
 rtl/mem_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, access sizes and an alignment helper.
package mips_pkg;

  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  function automatic logic is_aligned(input size_e sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_WORD: is_aligned = (addr_lo == 2'b00);
      SZ_HALF: is_aligned = !addr_lo[0];
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_store_merge.sv
// Store lane placement: converts access size and low address bits into byte
// enables and the write data replicated onto the addressed lanes.
module dm_store_merge
  import mips_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    be        = 4'b0000;
    lane_data = '0;
    case (size)
      SZ_WORD: begin
        be        = 4'b1111;
        lane_data = wdata;
      end
      SZ_HALF: begin
        be        = 4'b0011 << addr_lo;
        lane_data = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: word-addressed data memory with byte-lane stores and the
// MEM/WB register. Define DM_TRACE_EN to print each committed store in simulation.
module mem_stage
  import mips_pkg::*;
#(
  parameter int          DM_WORDS = 4096,
  parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC3,
  input  logic [31:0] Instr3,
  input  logic [31:0] Result3,
  input  logic [31:0] WriteData3,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] PC4,
  output logic [31:0] Instr4,
  output logic [31:0] Result4,
  output logic [31:0] RD4,
  output logic        adel_exc,
  output logic        ades_exc
);

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

  logic [31:0]   mem [DM_WORDS];
  logic [31:0]   off;
  logic [AW-1:0] index;
  logic          in_range;
  logic          aligned;
  logic          bad_addr;
  logic          is_load;
  logic          is_store;
  size_e         size;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic [31:0]   lane_mask;
  logic [31:0]   merged;
  logic          store_en;

  assign off      = Result3 - DM_BASE;
  assign index    = off[AW+1:2];
  assign in_range = (off < DM_BYTES);

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    case (Instr3[31:26])
      OP_SW:         begin is_store = 1'b1; size = SZ_WORD; end
      OP_SH:         begin is_store = 1'b1; size = SZ_HALF; end
      OP_SB:         begin is_store = 1'b1; size = SZ_BYTE; end
      OP_LW:         begin is_load  = 1'b1; size = SZ_WORD; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_LB, OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      default: ;
    endcase
  end

  assign aligned  = is_aligned(size, Result3[1:0]);
  assign bad_addr = !in_range || !aligned;

  dm_store_merge u_merge (
    .size      (size),
    .addr_lo   (Result3[1:0]),
    .wdata     (WriteData3),
    .be        (be),
    .lane_data (lane_data)
  );

  // Read-modify-write of the addressed word keeps the disabled lanes intact.
  assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged    = (mem[index] & ~lane_mask) | (lane_data & lane_mask);
  assign store_en  = is_store && !hold && !flush && !bad_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the memory is cleared by reset, which forces a register array
      // rather than an SRAM macro; a store in flight at reset is dropped.
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (store_en) begin
      mem[index] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC4      <= '0;
      Instr4   <= '0;
      Result4  <= '0;
      RD4      <= '0;
      adel_exc <= 1'b0;
      ades_exc <= 1'b0;
    end else if (flush) begin
      PC4      <= '0;
      Instr4   <= '0;
      Result4  <= '0;
      RD4      <= '0;
      adel_exc <= 1'b0;
      ades_exc <= 1'b0;
    end else if (!hold) begin
      // NOTE: non-blocking so RD4 samples the word as it was before this
      // edge's store; a following load sees the store one cycle later.
      PC4      <= PC3;
      Instr4   <= Instr3;
      Result4  <= Result3;
      RD4      <= in_range ? mem[index] : '0;
      adel_exc <= is_load && bad_addr;
      ades_exc <= is_store && bad_addr;
    end
  end

`ifdef DM_TRACE_EN
  always @(posedge clk) begin
    if (reset && store_en)
      $display("@%h: *%h <= %h", PC3, {Result3[31:2], 2'b00}, merged);
  end
`endif

endmodule
